// File: rtl/quadrature_step_decoder.sv
// Quadrature decoder: synchronises A/B, emits step/go_down/error pulses and keeps a position count.
// Optional build macro QUAD_SATURATE_EN makes the count saturate (and flag error) instead of wrapping.
module quadrature_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [WIDTH-1:0] q_next,
    output logic             step,
    output logic             go_down,
    output logic             error
);

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
    logic [1:0]             ab_s;
    state_t                 state_q, state_d;
    logic [2:0]             primeCnt_q, primeCnt_d;
    logic [1:0]             prevAb_q, prevAb_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   step_q, step_d;
    logic                   goDown_q, goDown_d;
    logic                   error_q, error_d;
    logic [1:0]             posPrev, posCur, delta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[SYNC_STAGES-2:0], quad_a};
            syncB_q <= {syncB_q[SYNC_STAGES-2:0], quad_b};
        end
    end

    assign ab_s = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

    // Position of each phase pair along the up cycle 00,10,11,01; the 2-bit
    // difference is then 1 for up, 3 for down and 2 for a skipped state.
    assign posPrev = {prevAb_q[0], prevAb_q[1] ^ prevAb_q[0]};
    assign posCur  = {ab_s[0], ab_s[1] ^ ab_s[0]};
    assign delta   = posCur - posPrev;

    always_comb begin
        state_d    = state_q;
        primeCnt_d = primeCnt_q;
        prevAb_d   = prevAb_q;
        count_d    = count_q;
        step_d     = 1'b0;
        error_d    = 1'b0;
        goDown_d   = goDown_q;
        case (state_q)
            PRIME: begin
                if (primeCnt_q == PRIME_LAST) begin
                    prevAb_d = ab_s;
                    state_d  = TRACK;
                end else begin
                    primeCnt_d = primeCnt_q + 3'd1;
                end
            end
            TRACK: begin
                prevAb_d = ab_s;
                case (delta)
                    2'd1: begin
                        step_d   = 1'b1;
                        goDown_d = 1'b0;
`ifdef QUAD_SATURATE_EN
                        if (count_q == COUNT_MAX) error_d = 1'b1;
                        else                      count_d = count_q + COUNT_ONE;
`else
                        count_d = count_q + COUNT_ONE;
`endif
                    end
                    2'd3: begin
                        step_d   = 1'b1;
                        goDown_d = 1'b1;
`ifdef QUAD_SATURATE_EN
                        if (count_q == '0) error_d = 1'b1;
                        else               count_d = count_q - COUNT_ONE;
`else
                        count_d = count_q - COUNT_ONE;
`endif
                    end
                    2'd2:    error_d = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = PRIME;
        endcase
        // Clear only touches the count; the pulses still report this cycle's decode.
        if (clear) count_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PRIME;
            primeCnt_q <= '0;
            prevAb_q   <= '0;
            count_q    <= '0;
            step_q     <= 1'b0;
            goDown_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            primeCnt_q <= primeCnt_d;
            prevAb_q   <= prevAb_d;
            count_q    <= count_d;
            step_q     <= step_d;
            goDown_q   <= goDown_d;
            error_q    <= error_d;
        end
    end

    assign q_next  = count_q;
    assign step    = step_q;
    assign go_down = goDown_q;
    assign error   = error_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Randomised self-checking bench for quadrature_step_decoder against a sample-history reference model.
// Honours QUAD_SATURATE_EN the same way the design does.
module tb_quadrature_step_decoder;

    localparam int WIDTH = 4;
    localparam int S     = 2;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             quad_a, quad_b, clear;
    logic [WIDTH-1:0] q_next;
    logic             step, go_down, error;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: every input pair sampled since reset, the running position
    // and the outputs expected after the most recent edge.
    logic [1:0] samp[$];
    int         edgeCount;
    int         expPos;
    bit         expStep, expDown, expErr;
    int         walkIdx;
    logic [1:0] upSeq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    quadrature_step_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .clear   (clear),
        .q_next  (q_next),
        .step    (step),
        .go_down (go_down),
        .error   (error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int posOf(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (upSeq[i] == ab) return i;
        return 0;
    endfunction

    // The first sample after reset is the baseline; sample j (j>=2) is compared
    // with sample j-1 and its result is visible after edge j+S.
    task automatic modelEdge(input logic [1:0] ab, input bit clr);
        int d;
        edgeCount++;
        samp.push_back(ab);
        expStep = 0;
        expErr  = 0;
        if (edgeCount >= S + 2) begin
            d = (posOf(samp[edgeCount-S-1]) - posOf(samp[edgeCount-S-2]) + 4) % 4;
            if (d == 1) begin
                expStep = 1;
                expDown = 0;
`ifdef QUAD_SATURATE_EN
                if (expPos == MOD - 1) expErr = 1;
                else                   expPos = expPos + 1;
`else
                expPos = (expPos + 1) % MOD;
`endif
            end else if (d == 3) begin
                expStep = 1;
                expDown = 1;
`ifdef QUAD_SATURATE_EN
                if (expPos == 0) expErr = 1;
                else             expPos = expPos - 1;
`else
                expPos = (expPos + MOD - 1) % MOD;
`endif
            end else if (d == 2) begin
                expErr = 1;
            end
        end
        if (clr) expPos = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input bit clr);
        quad_a = ab[1];
        quad_b = ab[0];
        clear  = clr;
        @(posedge clk);
        modelEdge(ab, clr);
        #1;
        checkOutput("q_next", q_next, expPos);
        checkOutput("step", step, expStep);
        checkOutput("go_down", go_down, expDown);
        checkOutput("error", error, expErr);
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        repeat (n) applyStimulus(ab, 1'b0);
    endtask

    task automatic modelReset();
        samp.delete();
        edgeCount = 0;
        expPos    = 0;
        expStep   = 0;
        expDown   = 0;
        expErr    = 0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_q_next", q_next, 0);
        checkOutput("rst_step", step, 0);
        checkOutput("rst_go_down", go_down, 0);
        checkOutput("rst_error", error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [1:0] nxt;
        int         r;
        bit         clr;

        reset  = 1'b1;
        quad_a = 1'b1;
        quad_b = 1'b1;
        clear  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_q_next", q_next, 0);
        checkOutput("init_step", step, 0);
        checkOutput("init_go_down", go_down, 0);
        checkOutput("init_error", error, 0);
        reset = 1'b0;

        hold(2'b11, 10);
        hold(2'b01, 4);
        hold(2'b00, 4);
        applyStimulus(2'b00, 1'b1);
        hold(2'b00, 3);

        for (int i = 1; i <= 4; i++) hold(upSeq[i % 4], 4);
        checkOutput("after_up4", q_next, 4);
        for (int i = 3; i >= -1; i--) hold(upSeq[(i + 4) % 4], 4);
`ifdef QUAD_SATURATE_EN
        checkOutput("after_down5", q_next, 0);
`else
        checkOutput("after_down5", q_next, MOD - 1);
`endif

        hold(2'b00, 4);
        hold(2'b11, 4);
        hold(2'b00, 4);
        applyStimulus(2'b00, 1'b1);
        hold(2'b00, 3);

        for (int i = 1; i <= 7; i++) hold(upSeq[i % 4], 3);
        checkOutput("before_clr_step", q_next, 7);
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b00, 1'b1);
        checkOutput("clr_step_pulse", step, 1);
        hold(2'b00, 3);

        for (int i = 1; i <= 9; i++) hold(upSeq[i % 4], 3);
        checkOutput("before_reset", q_next, 9);
        doReset();
        hold(upSeq[1], 5);
        for (int i = 2; i <= 5; i++) hold(upSeq[i % 4], 3);

        walkIdx = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)       walkIdx = (walkIdx + 1) % 4;
                else if (r < 8)  walkIdx = (walkIdx + 3) % 4;
                else if (r == 9) walkIdx = (walkIdx + 2) % 4;
                nxt = upSeq[walkIdx];
                clr = ($urandom_range(0, 29) == 0);
                applyStimulus(nxt, clr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
